cam_match_sequencer: RTL and testbench

// - Parametrised multi-match priority encoder for the ex_cam datapath.
// - Takes a registered CAM hit vector and returns every set line index, one per beat, in priority order.
// - Uses valid/ready on both sides and emits an explicit miss beat for an all-zero vector.
// - Sits between the CAM compare array and the result/readout FSM.

---
 rtl/cam_pkg.sv | 24 ++
 rtl/cam_prio_enc.sv | 29 ++
 rtl/cam_match_sequencer.sv | 110 +++++++++++
 tb/tb_cam_match_sequencer.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/cam_pkg.sv
// Shared types and helpers for the CAM match sequencer and other ex_cam blocks.
// Helpers take vectors zero-extended to CAM_MAX_W, so they serve any depth up to 64 lines.
package cam_pkg;

  localparam int CAM_MAX_SIZE = 6;
  localparam int CAM_MAX_W    = 2**CAM_MAX_SIZE;

  typedef enum logic {IDLE, SCAN} cam_seq_state_t;

  function automatic logic [CAM_MAX_SIZE+1:0] popcount(input logic [CAM_MAX_W-1:0] v);
    logic [CAM_MAX_SIZE+1:0] cnt;
    cnt = '0;
    for (int i = 0; i < CAM_MAX_W; i++) begin
      cnt = cnt + (CAM_MAX_SIZE+2)'(v[i]);
    end
    return cnt;
  endfunction

  function automatic logic [CAM_MAX_W-1:0] onehot_clr(input logic [CAM_MAX_W-1:0] v,
                                                      input logic [CAM_MAX_SIZE-1:0] idx);
    return v & ~(CAM_MAX_W'(1) << idx);
  endfunction

endpackage

// File: rtl/cam_prio_enc.sv
// Combinational priority encoder: vector -> highest (MSB_FIRST=1) or lowest set index, plus any-set.
// Zero latency; an empty vector yields index 0 with any_o low.
module cam_prio_enc #(
  parameter int SIZE      = 5,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic [2**SIZE-1:0] vec_i,
  output logic [SIZE-1:0]    index_o,
  output logic               any_o
);

  localparam int WIDTH = 2**SIZE;

  // The last set bit visited wins, so the scan direction selects the priority.
  always_comb begin
    index_o = '0;
    any_o   = |vec_i;
    if (MSB_FIRST) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (vec_i[i]) index_o = SIZE'(i);
      end
    end else begin
      for (int i = WIDTH-1; i >= 0; i--) begin
        if (vec_i[i]) index_o = SIZE'(i);
      end
    end
  end

endmodule

// File: rtl/cam_match_sequencer.sv
// Emits every set line of an accepted CAM hit vector, one beat per cycle in priority order (miss beat if empty).
// First beat the cycle after accept; outputs hold while out_ready_i is low; accepts only when idle.
module cam_match_sequencer
  import cam_pkg::*;
#(
  parameter int SIZE      = 5,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [2**SIZE-1:0] match_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic              out_hit_o,
  output logic [SIZE-1:0]   out_index_o,
  output logic              out_last_o,
  output logic [SIZE:0]     match_count_o,
  output logic              busy_o
);

  localparam int WIDTH = 2**SIZE;

  cam_seq_state_t   state_q, state_d;
  logic [WIDTH-1:0] pending_q, pending_d;
  logic [SIZE:0]    count_q, count_d;
  logic             miss_q, miss_d;

  logic [SIZE-1:0]  enc_idx;
  logic             enc_any;
  logic             single_left;

  cam_prio_enc #(.SIZE(SIZE), .MSB_FIRST(MSB_FIRST)) u_prio_enc (
    .vec_i   (pending_q),
    .index_o (enc_idx),
    .any_o   (enc_any)
  );

  assign single_left = enc_any && ((pending_q & (pending_q - WIDTH'(1))) == '0);

  always_comb begin
    in_ready_o    = 1'b0;
    out_valid_o   = 1'b0;
    out_hit_o     = 1'b0;
    out_index_o   = '0;
    out_last_o    = 1'b0;
    match_count_o = count_q;
    busy_o        = 1'b0;

    state_d   = state_q;
    pending_d = pending_q;
    count_d   = count_q;
    miss_d    = miss_q;

    case (state_q)
      IDLE: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          pending_d = match_i;
          count_d   = (SIZE+1)'(popcount(CAM_MAX_W'(match_i)));
          miss_d    = (match_i == '0);
          state_d   = SCAN;
        end
      end
      SCAN: begin
        busy_o      = 1'b1;
        out_valid_o = 1'b1;
        out_hit_o   = ~miss_q;
        out_index_o = miss_q ? '0 : enc_idx;
        out_last_o  = miss_q | single_left;
        if (out_ready_i) begin
          if (!miss_q) begin
            pending_d = WIDTH'(onehot_clr(CAM_MAX_W'(pending_q), CAM_MAX_SIZE'(enc_idx)));
          end
          if (out_last_o) begin
            state_d   = IDLE;
            pending_d = '0;
            miss_d    = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Flush overrides any accept or beat this cycle; the last count stays visible.
    if (flush_i) begin
      state_d   = IDLE;
      pending_d = '0;
      miss_d    = 1'b0;
      count_d   = count_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      pending_q <= '0;
      count_q   <= '0;
      miss_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      count_q   <= count_d;
      miss_q    <= miss_d;
    end
  end

endmodule

// File: tb/tb_cam_match_sequencer.sv
// Drives an MSB-first and an LSB-first sequencer with identical stimulus and checks each beat
// against index lists computed directly from the vector's set bits.
module tb_cam_match_sequencer;

  localparam int SIZE  = 5;
  localparam int WIDTH = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              flush;
  logic              in_valid;
  logic [WIDTH-1:0]  match;
  logic              out_ready;

  logic              o1_in_rdy, o1_vld, o1_hit, o1_last, o1_busy;
  logic [SIZE-1:0]   o1_idx;
  logic [SIZE:0]     o1_cnt;
  logic              o0_in_rdy, o0_vld, o0_hit, o0_last, o0_busy;
  logic [SIZE-1:0]   o0_idx;
  logic [SIZE:0]     o0_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cam_match_sequencer #(.SIZE(SIZE), .MSB_FIRST(1'b1)) dut_msb (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(o1_in_rdy), .match_i(match),
    .out_valid_o(o1_vld), .out_ready_i(out_ready), .out_hit_o(o1_hit),
    .out_index_o(o1_idx), .out_last_o(o1_last), .match_count_o(o1_cnt), .busy_o(o1_busy)
  );

  cam_match_sequencer #(.SIZE(SIZE), .MSB_FIRST(1'b0)) dut_lsb (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(o0_in_rdy), .match_i(match),
    .out_valid_o(o0_vld), .out_ready_i(out_ready), .out_hit_o(o0_hit),
    .out_index_o(o0_idx), .out_last_o(o0_last), .match_count_o(o0_cnt), .busy_o(o0_busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag, input int cnt);
    chk({tag, "_m_inrdy"}, 64'(o1_in_rdy), 64'(1));
    chk({tag, "_l_inrdy"}, 64'(o0_in_rdy), 64'(1));
    chk({tag, "_m_vld"},   64'(o1_vld),    64'(0));
    chk({tag, "_l_vld"},   64'(o0_vld),    64'(0));
    chk({tag, "_m_busy"},  64'(o1_busy),   64'(0));
    chk({tag, "_l_busy"},  64'(o0_busy),   64'(0));
    chk({tag, "_m_hit"},   64'(o1_hit),    64'(0));
    chk({tag, "_m_idx"},   64'(o1_idx),    64'(0));
    chk({tag, "_m_last"},  64'(o1_last),   64'(0));
    chk({tag, "_l_last"},  64'(o0_last),   64'(0));
    chk({tag, "_m_cnt"},   64'(o1_cnt),    64'(cnt));
    chk({tag, "_l_cnt"},   64'(o0_cnt),    64'(cnt));
  endtask

  task automatic check_beat(input string tag, input logic hit, input int i1, input int i0,
                            input logic last, input int cnt);
    chk({tag, "_m_vld"},   64'(o1_vld),    64'(1));
    chk({tag, "_l_vld"},   64'(o0_vld),    64'(1));
    chk({tag, "_m_inrdy"}, 64'(o1_in_rdy), 64'(0));
    chk({tag, "_m_busy"},  64'(o1_busy),   64'(1));
    chk({tag, "_m_hit"},   64'(o1_hit),    64'(hit));
    chk({tag, "_l_hit"},   64'(o0_hit),    64'(hit));
    chk({tag, "_m_idx"},   64'(o1_idx),    64'(i1));
    chk({tag, "_l_idx"},   64'(o0_idx),    64'(i0));
    chk({tag, "_m_last"},  64'(o1_last),   64'(last));
    chk({tag, "_l_last"},  64'(o0_last),   64'(last));
    chk({tag, "_m_cnt"},   64'(o1_cnt),    64'(cnt));
    chk({tag, "_l_cnt"},   64'(o0_cnt),    64'(cnt));
  endtask

  // Presents vec, then consumes its beats. stall_mode 0: always ready, 1: random ready,
  // 2: hold ready low stall_n cycles on the first beat. flush_beat>=0 flushes during that beat.
  task automatic run_vector(input string tag, input logic [WIDTH-1:0] vec, input int stall_mode,
                            input int stall_n, input int flush_beat);
    int l_msb[$];
    int l_lsb[$];
    int cnt;
    int nbeats;
    int stalls;
    for (int i = WIDTH-1; i >= 0; i--) if (vec[i]) l_msb.push_back(i);
    for (int i = 0; i < WIDTH; i++)    if (vec[i]) l_lsb.push_back(i);
    cnt    = l_msb.size();
    nbeats = (cnt == 0) ? 1 : cnt;

    chk({tag, "_pre_inrdy"}, 64'(o1_in_rdy & o0_in_rdy), 64'(1));
    in_valid  = 1'b1;
    match     = vec;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;

    for (int b = 0; b < nbeats; b++) begin
      stalls = 0;
      forever begin
        match    = $urandom;
        in_valid = 1'($urandom_range(0, 1));
        case (stall_mode)
          1:       out_ready = ($urandom_range(0, 3) != 0);
          2:       out_ready = !(b == 0 && stalls < stall_n);
          default: out_ready = 1'b1;
        endcase
        if (b == flush_beat) begin
          out_ready = 1'b1;
          flush     = 1'b1;
        end
        if (cnt == 0) check_beat({tag, "_miss"}, 1'b0, 0, 0, 1'b1, 0);
        else check_beat($sformatf("%s_b%0d", tag, b), 1'b1, l_msb[b], l_lsb[b], (b == nbeats-1), cnt);
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        if (out_ready) break;
        stalls++;
      end
      if (b == flush_beat) break;
    end
    out_ready = 1'b0;
    check_idle({tag, "_end"}, cnt);
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    match     = '0;
    out_ready = 1'b0;
    #2;
    check_idle("reset", 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("post_reset", 0);

    run_vector("ends",  32'h8000_0001, 0, 0, -1);
    run_vector("miss",  32'h0000_0000, 0, 0, -1);
    run_vector("stall", 32'h0000_0124, 2, 3, -1);
    run_vector("all",   32'hFFFF_FFFF, 0, 0, -1);
    run_vector("flush", 32'h0000_00F0, 0, 0, 1);
    run_vector("after_flush", 32'h0000_0001, 0, 0, -1);

    for (int n = 0; n < 24; n++) begin
      logic [WIDTH-1:0] v;
      v = $urandom & $urandom & $urandom;
      if (n % 8 == 3) v = '0;
      run_vector($sformatf("rnd%0d", n), v, 1, 0, -1);
    end

    // Asynchronous reset in the middle of a scan, asserted and released away from clock edges.
    in_valid = 1'b1;
    match    = 32'h0000_0124;
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("rst_mid_vld", 64'(o1_vld & o0_vld), 64'(1));
    out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_idle("async_rst", 0);
    #3 rst_n = 1'b1;
    @(negedge clk);
    check_idle("rst_release", 0);
    @(negedge clk);
    check_idle("rst_release2", 0);
    run_vector("post_rst", 32'h0000_4002, 0, 0, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
